// File: rtl/sc_pkg.sv
// Shared types and constants for the second-chance hash table update path.
// Holds request opcodes, response status codes, the bucket entry layout for
// the default widths, and the RAM read latency the forwarder depth follows.
package sc_pkg;

  localparam int SC_KEY_W      = 8;
  localparam int SC_DATA_W     = 16;
  localparam int SC_ADDR_W     = 6;
  localparam int SC_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_HIT       = 3'd0,
    ST_MISS      = 3'd1,
    ST_INSERTED  = 3'd2,
    ST_UPDATED   = 3'd3,
    ST_DELETED   = 3'd4,
    ST_COLLISION = 3'd5,
    ST_EVICTED   = 3'd6
  } status_e;

  // Bucket layout as stored in the table RAM: {valid, key, data}.
  typedef struct packed {
    logic                 valid;
    logic [SC_KEY_W-1:0]  key;
    logic [SC_DATA_W-1:0] data;
  } entry_t;

  // The unused encoding 2'b11 behaves as a lookup.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return OP_INSERT;
      2'b10:   return OP_DELETE;
      default: return OP_LOOKUP;
    endcase
  endfunction

endpackage

// File: rtl/cam_forwarder.sv
// Write-forwarding CAM: remembers the last DEPTH table writes and patches a
// stale RAM word whose bucket index matches one of them (newest write wins).
// Ports: clk/reset/clk_en; new_* = RAM word under test (index, valid, payload);
// forward_* = write being issued this cycle; out_* = corrected word.
module cam_forwarder
  import sc_pkg::*;
#(
  parameter int KEY_W  = SC_ADDR_W,
  parameter int DATA_W = SC_KEY_W + SC_DATA_W,
  parameter int DEPTH  = SC_RD_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [KEY_W-1:0]  new_key_i,
  input  logic              new_valid_i,
  input  logic [DATA_W-1:0] new_data_i,
  input  logic [KEY_W-1:0]  forward_key_i,
  input  logic [DATA_W-1:0] forward_data_i,
  input  logic              forward_write_i,
  input  logic              forward_del_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  // Slot 0 is the write from the previous enabled cycle, slot DEPTH-1 the
  // oldest one still invisible to the RAM read currently being corrected.
  logic [DEPTH-1:0]  slot_vld;   // a write (or delete) happened in that slot
  logic [DEPTH-1:0]  slot_wr;    // valid bit that was written
  logic [KEY_W-1:0]  slot_key  [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];

  // Empty cycles shift in an unused slot so slot age stays tied to cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld <= '0;
      slot_wr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_key[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (clk_en) begin
      slot_vld[0]  <= forward_write_i || forward_del_i;
      slot_wr[0]   <= forward_write_i;
      slot_key[0]  <= forward_key_i;
      slot_data[0] <= forward_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        slot_vld[i]  <= slot_vld[i-1];
        slot_wr[i]   <= slot_wr[i-1];
        slot_key[i]  <= slot_key[i-1];
        slot_data[i] <= slot_data[i-1];
      end
    end
  end

  // Walk oldest to newest so the most recent matching write overrides.
  always_comb begin
    out_valid_o = new_valid_i;
    out_data_o  = new_data_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_key[i] == new_key_i)) begin
        out_valid_o = slot_wr[i];
        out_data_o  = slot_data[i];
      end
    end
  end

endmodule

// File: rtl/sc_bucket_updater.sv
// Three-stage read-modify-write pipeline for the direct-mapped second-chance
// hash table: S0 issues the RAM read, S1 waits on RAM latency, S2 corrects the
// word through cam_forwarder, decides the write-back and registers the response.
// Ports: req_* request handshake in; mem_* table RAM (2-cycle read, sole writer);
// resp_* response out, held until resp_ready_i. Whole pipe stalls on response
// backpressure. Build macro SC_EVICT_EN: insert over a different key evicts it
// instead of reporting a collision.
module sc_bucket_updater
  import sc_pkg::*;
#(
  parameter int KEY_WIDTH  = SC_KEY_W,
  parameter int DATA_WIDTH = SC_DATA_W,
  parameter int ADDR_WIDTH = SC_ADDR_W   // must not exceed KEY_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [1:0]                      req_op_i,
  input  logic [KEY_WIDTH-1:0]            req_key_i,
  input  logic [DATA_WIDTH-1:0]           req_data_i,
  output logic                            mem_en_o,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr_o,
  input  logic [KEY_WIDTH+DATA_WIDTH:0]   mem_rd_data_i,
  output logic                            mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]           mem_wr_addr_o,
  output logic [KEY_WIDTH+DATA_WIDTH:0]   mem_wr_data_o,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [2:0]                      resp_status_o,
  output logic [KEY_WIDTH-1:0]            resp_key_o,
  output logic [DATA_WIDTH-1:0]           resp_data_o
);

  localparam int KD_WIDTH = KEY_WIDTH + DATA_WIDTH;

  logic en;
  assign en            = !(resp_valid_o && !resp_ready_i);
  assign req_ready_o   = en;
  assign mem_en_o      = en;
  assign mem_rd_addr_o = req_key_i[ADDR_WIDTH-1:0];

  // ---------------- stage registers ----------------
  logic                  s1_vld, s2_vld;
  op_e                   s1_op, s2_op;
  logic [KEY_WIDTH-1:0]  s1_key, s2_key;
  logic [DATA_WIDTH-1:0] s1_data, s2_data;

  // Acceptance only happens while en is high, so req_valid_i alone marks S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_op   <= OP_LOOKUP;
      s1_key  <= '0;
      s1_data <= '0;
      s2_vld  <= 1'b0;
      s2_op   <= OP_LOOKUP;
      s2_key  <= '0;
      s2_data <= '0;
    end else if (en) begin
      s1_vld  <= req_valid_i;
      s1_op   <= decode_op(req_op_i);
      s1_key  <= req_key_i;
      s1_data <= req_data_i;
      s2_vld  <= s1_vld;
      s2_op   <= s1_op;
      s2_key  <= s1_key;
      s2_data <= s1_data;
    end
  end

  // ---------------- S2: forwarding ----------------
  logic                  cor_valid;
  logic [KD_WIDTH-1:0]   cor_kd;
  logic [KEY_WIDTH-1:0]  cor_key;
  logic [DATA_WIDTH-1:0] cor_data;
  logic                  cor_match;

  cam_forwarder #(
    .KEY_W  (ADDR_WIDTH),
    .DATA_W (KD_WIDTH),
    .DEPTH  (SC_RD_LATENCY)
  ) u_fwd (
    .clk             (clk),
    .reset           (reset),
    .clk_en          (en),
    .new_key_i       (s2_key[ADDR_WIDTH-1:0]),
    .new_valid_i     (mem_rd_data_i[KD_WIDTH]),
    .new_data_i      (mem_rd_data_i[KD_WIDTH-1:0]),
    .forward_key_i   (mem_wr_addr_o),
    .forward_data_i  (mem_wr_data_o[KD_WIDTH-1:0]),
    .forward_write_i (mem_wr_en_o && mem_wr_data_o[KD_WIDTH]),
    .forward_del_i   (mem_wr_en_o && !mem_wr_data_o[KD_WIDTH]),
    .out_valid_o     (cor_valid),
    .out_data_o      (cor_kd)
  );

  assign cor_key   = cor_kd[KD_WIDTH-1:DATA_WIDTH];
  assign cor_data  = cor_kd[DATA_WIDTH-1:0];
  assign cor_match = cor_valid && (cor_key == s2_key);

  // ---------------- S2: decision ----------------
  logic                  dec_wr;
  logic                  dec_wr_valid;
  logic [DATA_WIDTH-1:0] dec_wr_data;
  status_e               dec_status;
  logic [KEY_WIDTH-1:0]  dec_key;
  logic [DATA_WIDTH-1:0] dec_data;

  always_comb begin
    dec_wr       = 1'b0;
    dec_wr_valid = 1'b0;
    dec_wr_data  = '0;
    dec_status   = ST_MISS;
    dec_key      = s2_key;
    dec_data     = '0;
    if (s2_vld) begin
      unique case (s2_op)
        OP_INSERT: begin
          if (cor_match) begin
            dec_wr       = 1'b1;
            dec_wr_valid = 1'b1;
            dec_wr_data  = s2_data;
            dec_status   = ST_UPDATED;
            dec_data     = cor_data;
          end else if (!cor_valid) begin
            dec_wr       = 1'b1;
            dec_wr_valid = 1'b1;
            dec_wr_data  = s2_data;
            dec_status   = ST_INSERTED;
          end else begin
            // Bucket held by a different key: report the occupant.
`ifdef SC_EVICT_EN
            dec_wr       = 1'b1;
            dec_wr_valid = 1'b1;
            dec_wr_data  = s2_data;
            dec_status   = ST_EVICTED;
`else
            dec_status   = ST_COLLISION;
`endif
            dec_key      = cor_key;
            dec_data     = cor_data;
          end
        end
        OP_DELETE: begin
          if (cor_match) begin
            dec_wr     = 1'b1;     // writes {0, K, 0}
            dec_status = ST_DELETED;
            dec_data   = cor_data;
          end
        end
        default: begin
          if (cor_match) begin
            dec_status = ST_HIT;
            dec_data   = cor_data;
          end
        end
      endcase
    end
  end

  // A stalled or resetting cycle must not write: the same S2 entry will be
  // re-evaluated (or dropped), and the forwarder must not record it twice.
  assign mem_wr_en_o   = dec_wr && en && !reset;
  assign mem_wr_addr_o = s2_key[ADDR_WIDTH-1:0];
  assign mem_wr_data_o = {dec_wr_valid, s2_key, dec_wr_data};

  // ---------------- response register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_o  <= 1'b0;
      resp_status_o <= '0;
      resp_key_o    <= '0;
      resp_data_o   <= '0;
    end else if (en) begin
      resp_valid_o <= s2_vld;
      if (s2_vld) begin
        resp_status_o <= dec_status;
        resp_key_o    <= dec_key;
        resp_data_o   <= dec_data;
      end
    end
  end

endmodule

// File: tb/tb_sc_bucket_updater.sv
// Directed bench for sc_bucket_updater with a behavioural 2-cycle table RAM.
// Checks reset state, latency, forwarding from both slots, collision/evict,
// backpressure stall behaviour and reset while a request is in flight.
module tb_sc_bucket_updater;
  import sc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_key = '0;
  logic [15:0] req_data = '0;
  logic        mem_en;
  logic [5:0]  mem_rd_addr;
  logic [24:0] mem_rd_data;
  logic        mem_wr_en;
  logic [5:0]  mem_wr_addr;
  logic [24:0] mem_wr_data;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [2:0]  resp_status;
  logic [7:0]  resp_key;
  logic [15:0] resp_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_bucket_updater dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_key_i     (req_key),
    .req_data_i    (req_data),
    .mem_en_o      (mem_en),
    .mem_rd_addr_o (mem_rd_addr),
    .mem_rd_data_i (mem_rd_data),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_addr_o (mem_wr_addr),
    .mem_wr_data_o (mem_wr_data),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_status_o (resp_status),
    .resp_key_o    (resp_key),
    .resp_data_o   (resp_data)
  );

  // Table RAM: read issued at T returns at T+2, write at W visible to reads at W+1.
  logic [24:0] ram [64];
  logic [24:0] rd_q1, rd_q2;
  logic        clr = 1'b1;
  int          wr_count;

  assign mem_rd_data = rd_q2;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      rd_q1    <= '0;
      rd_q2    <= '0;
      wr_count <= 0;
    end else begin
      if (mem_en) begin
        rd_q1 <= ram[mem_rd_addr];
        rd_q2 <= rd_q1;
      end
      if (mem_wr_en) begin
        ram[mem_wr_addr] <= mem_wr_data;
        wr_count <= wr_count + 1;
      end
    end
  end

  // Response collector: {status, key, data} per completed handshake.
  logic [26:0] rq[$];
  always @(posedge clk) begin
    if (!reset && resp_valid && resp_ready) rq.push_back({resp_status, resp_key, resp_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] k, input logic [15:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_data  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic clear_table();
    idle(4);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [2:0] st, input logic [7:0] k,
                            input logic [15:0] d);
    int n = 0;
    logic [26:0] got;
    while (rq.size() == 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk({tag, "_present"}, 32'(rq.size() != 0), 32'd1);
    if (rq.size() != 0) begin
      got = rq.pop_front();
      chk(tag, 32'(got), 32'({st, k, d}));
    end
  endtask

  initial begin
    // ---- reset state ----
    idle(2);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fields", 32'({resp_status, resp_key, resp_data}), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    reset = 1'b0;
    clr   = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // ---- lookup on empty table, 3-cycle latency ----
    issue(2'b00, 8'h05, 16'h0);
    chk("lat_ready_t1", 32'(req_ready), 32'd1);
    idle(1);
    chk("lat_not_yet", 32'(resp_valid), 32'd0);
    chk("lat_ready_t2", 32'(req_ready), 32'd1);
    idle(1);
    chk("lat_valid_t3", 32'(resp_valid), 32'd1);
    chk("lat_fields", 32'({resp_status, resp_key, resp_data}), 32'({ST_MISS, 8'h05, 16'h0}));
    chk("lat_ready_t3", 32'(req_ready), 32'd1);
    expect_rsp("empty_lookup", ST_MISS, 8'h05, 16'h0);

    // ---- insert then immediate lookup: newer forwarder slot ----
    clear_table();
    issue(2'b01, 8'h05, 16'hBEEF);
    issue(2'b00, 8'h05, 16'h0);
    expect_rsp("ins_beef", ST_INSERTED, 8'h05, 16'h0);
    expect_rsp("hit_newer", ST_HIT, 8'h05, 16'hBEEF);

    // ---- insert, bubble, delete: older forwarder slot ----
    clear_table();
    issue(2'b01, 8'h05, 16'h1111);
    idle(1);
    issue(2'b10, 8'h05, 16'h0);
    idle(3);
    issue(2'b00, 8'h05, 16'h0);
    expect_rsp("ins_1111", ST_INSERTED, 8'h05, 16'h0);
    expect_rsp("del_older", ST_DELETED, 8'h05, 16'h1111);
    expect_rsp("lookup_after_del", ST_MISS, 8'h05, 16'h0);
    chk("del_writes", 32'(wr_count), 32'd2);

    // ---- same index, different key ----
    clear_table();
    issue(2'b01, 8'h05, 16'h0001);
    issue(2'b01, 8'h45, 16'h0002);
    issue(2'b11, 8'h45, 16'h0);     // encoding 11 acts as lookup
    expect_rsp("ins_05", ST_INSERTED, 8'h05, 16'h0);
`ifdef SC_EVICT_EN
    expect_rsp("evict", ST_EVICTED, 8'h05, 16'h0001);
    expect_rsp("hit_after_evict", ST_HIT, 8'h45, 16'h0002);
    chk("evict_writes", 32'(wr_count), 32'd2);
`else
    expect_rsp("collision", ST_COLLISION, 8'h05, 16'h0001);
    expect_rsp("miss_after_coll", ST_MISS, 8'h45, 16'h0);
    chk("coll_writes", 32'(wr_count), 32'd1);
`endif

    // ---- backpressure stall with three requests in flight ----
    clear_table();
    resp_ready = 1'b0;
    issue(2'b01, 8'h07, 16'hAAAA);
    issue(2'b01, 8'h07, 16'hBBBB);
    issue(2'b00, 8'h07, 16'h0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_resp", 32'({resp_valid, resp_status, resp_key, resp_data}),
          32'({1'b1, ST_INSERTED, 8'h07, 16'h0}));
      chk("stall_no_wr", 32'(mem_wr_en), 32'd0);
      chk("stall_wr_count", 32'(wr_count), 32'd1);
      idle(1);
    end
    resp_ready = 1'b1;
    expect_rsp("stall_r1", ST_INSERTED, 8'h07, 16'h0);
    expect_rsp("stall_r2", ST_UPDATED, 8'h07, 16'hAAAA);
    expect_rsp("stall_r3", ST_HIT, 8'h07, 16'hBBBB);
    chk("stall_writes", 32'(wr_count), 32'd2);

    // ---- reset while an insert sits in S1 ----
    clear_table();
    issue(2'b01, 8'h09, 16'h1234);
    reset = 1'b1;
    chk("midrst_wr_en_a", 32'(mem_wr_en), 32'd0);
    idle(1);
    chk("midrst_wr_en_b", 32'(mem_wr_en), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    idle(1);
    reset = 1'b0;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    idle(5);
    chk("midrst_no_resp", 32'(rq.size()), 32'd0);
    chk("midrst_no_write", 32'(wr_count), 32'd0);
    issue(2'b00, 8'h09, 16'h0);
    expect_rsp("midrst_lookup", ST_MISS, 8'h09, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
